// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_controller
// Bridges 32-bit MEM-stage word requests onto a 16-bit asynchronous SRAM
// (256K x 16). Each word access becomes two halfword accesses, low then high,
// each held for ACCESS_CYCLES clocks. While an access is in flight, ready is
// low so the pipeline stays frozen.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   rd_en, wr_en    - level requests from MEM stage (wr_en wins if both high)
//   address         - byte address (BASE_ADDR is subtracted, [1:0] ignored)
//   write_data      - store data
//   read_data       - registered load data, holds between reads
//   ready           - high when idle with no request, or access complete
//   SRAM_DQ         - bidirectional SRAM data bus
//   SRAM_ADDR       - SRAM halfword address {word index, half select}
//   SRAM_WE_N/OE_N  - active-low write / output enables (registered)
//   SRAM_CE_N/UB_N/LB_N - tied active
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(ACCESS_CYCLES - 1);

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [16:0] idx_r;
    logic [31:0] data_r;
    logic        wr_op_r;
    logic [31:0] read_data_r;
    logic [17:0] sram_addr_r;
    logic        we_n_r, oe_n_r;
    logic        dq_oe_r;
    logic [15:0] dq_out_r;

    logic        req_s;
    logic        last_s;
    logic [16:0] req_idx_s;
    logic [16:0] cur_idx_s;
    logic [31:0] cur_data_s;
    logic        cur_wr_s;
    logic        acc_s;
    logic        high_s;

    assign req_s     = rd_en | wr_en;
    assign last_s    = (cnt_r == CNT_LAST);
    // Wrap-around subtraction; only index bits 16:0 reach the SRAM.
    assign req_idx_s = 17'((address - BASE_ADDR) >> 2);

    // In IDLE the outputs for the first LOW cycle are built from the live
    // request, because the latched copies are only loaded on that same edge.
    assign cur_idx_s  = (state_r == ST_IDLE) ? req_idx_s  : idx_r;
    assign cur_data_s = (state_r == ST_IDLE) ? write_data : data_r;
    assign cur_wr_s   = (state_r == ST_IDLE) ? wr_en      : wr_op_r;

    assign acc_s  = (state_s == ST_LOW) || (state_s == ST_HIGH);
    assign high_s = (state_s == ST_HIGH);

    // Next-state, cycle counter and ready decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ready   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready = ~req_s;
                cnt_s = 3'd0;
                if (req_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    cnt_s   = 3'd0;
                    state_s = ST_HIGH;
                end else begin
                    cnt_s   = cnt_r + 3'd1;
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (last_s) begin
                    cnt_s   = 3'd0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r + 3'd1;
                    state_s = ST_HIGH;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                cnt_s   = 3'd0;
                state_s = ST_IDLE;
            end
            default: begin
                cnt_s   = 3'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Latch the request when it is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= 17'd0;
            data_r  <= 32'd0;
            wr_op_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            idx_r   <= req_idx_s;
            data_r  <= write_data;
            wr_op_r <= wr_en;
        end else begin
            idx_r   <= idx_r;
            data_r  <= data_r;
            wr_op_r <= wr_op_r;
        end
    end

    // Registered SRAM strobes, address and bus drive, decoded from next state.
    // dq_oe_r and oe_n_r come from the same op bit, so DQ is never driven
    // while the SRAM has its outputs enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr_r <= 18'd0;
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            we_n_r  <= ~(acc_s & cur_wr_s);
            oe_n_r  <= ~(acc_s & ~cur_wr_s);
            dq_oe_r <= acc_s & cur_wr_s;
            if (acc_s) begin
                sram_addr_r <= {cur_idx_s, high_s};
                dq_out_r    <= high_s ? cur_data_s[31:16] : cur_data_s[15:0];
            end else begin
                sram_addr_r <= sram_addr_r;
                dq_out_r    <= dq_out_r;
            end
        end
    end

    // Capture each read halfword on the edge that ends its final cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_r <= 32'd0;
        end else if (!wr_op_r && last_s && (state_r == ST_LOW)) begin
            read_data_r[15:0] <= SRAM_DQ;
        end else if (!wr_op_r && last_s && (state_r == ST_HIGH)) begin
            read_data_r[31:16] <= SRAM_DQ;
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign read_data = read_data_r;
    assign SRAM_ADDR = sram_addr_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_OE_N = oe_n_r;
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_controller
// Drives sram_controller instances (ACCESS_CYCLES = 2, 1, 4) from shared
// request inputs, each attached to its own behavioural 256K x 16 SRAM.
// Expected values come from a word-level reference memory indexed by the
// address map rule, plus the latency rule 2*ACCESS_CYCLES+1.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int AC  = 2;
    localparam int LAT = 2 * AC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic        probe_en;

    logic [31:0] rdata2, rdata1, rdata4;
    logic        ready2, ready1, ready4;
    wire  [15:0] dq2, dq1, dq4;
    logic [17:0] addr2, addr1, addr4;
    logic        we_n2, we_n1, we_n4, oe_n2, oe_n1, oe_n4;
    logic        ce_n2, ce_n1, ce_n4, ub_n2, ub_n1, ub_n4, lb_n2, lb_n1, lb_n4;

    logic [15:0] mem2 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem4 [0:262143];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(rdata2), .ready(ready2), .SRAM_DQ(dq2),
        .SRAM_ADDR(addr2), .SRAM_WE_N(we_n2), .SRAM_OE_N(oe_n2), .SRAM_CE_N(ce_n2),
        .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2));

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1),
        .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1),
        .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1));

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(rdata4), .ready(ready4), .SRAM_DQ(dq4),
        .SRAM_ADDR(addr4), .SRAM_WE_N(we_n4), .SRAM_OE_N(oe_n4), .SRAM_CE_N(ce_n4),
        .SRAM_UB_N(ub_n4), .SRAM_LB_N(lb_n4));

    // Behavioural asynchronous SRAMs: drive on OE, store while WE is low
    assign dq2 = (!oe_n2 && we_n2) ? mem2[addr2] : 16'hzzzz;
    assign dq1 = (!oe_n1 && we_n1) ? mem1[addr1] : 16'hzzzz;
    assign dq4 = (!oe_n4 && we_n4) ? mem4[addr4] : 16'hzzzz;
    // Weak-intent probe: zero on the bus when the controller must not drive
    assign dq2 = probe_en ? 16'h0000 : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_n2) mem2[addr2] <= dq2;
        if (!we_n1) mem1[addr1] <= dq1;
        if (!we_n4) mem4[addr4] <= dq4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off / 32'd4) % 32'd131072;
    endfunction

    // One full access on the AC=2 instance; entered and left just after a posedge
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] data, input string tag);
        int unsigned idx;
        bit          known;
        bit          hi;
        logic [31:0] exp_rd;
        idx    = model_idx(addr);
        known  = ref_mem.exists(idx);
        exp_rd = 32'd0;
        if (known) exp_rd = ref_mem[idx];
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        for (int c = 0; c <= LAT; c++) begin
            probe_en = (c == 0) || (c == LAT);
            @(negedge clk);
            if (c == 0) begin
                check({tag, "/c0_ready"}, 32'(ready2), 32'd0);
                check({tag, "/c0_we_n"}, 32'(we_n2), 32'd1);
                check({tag, "/c0_dq"}, 32'(dq2), 32'd0);
            end else if (c < LAT) begin
                hi = (c > AC);
                check({tag, "/ready"}, 32'(ready2), 32'd0);
                check({tag, "/addr"}, 32'(addr2), 32'(idx * 2 + 32'(hi)));
                check({tag, "/we_n"}, 32'(we_n2), 32'(!wr));
                check({tag, "/oe_n"}, 32'(oe_n2), 32'(wr));
                if (wr) check({tag, "/dq"}, 32'(dq2), hi ? {16'd0, data[31:16]} : {16'd0, data[15:0]});
            end else begin
                check({tag, "/done_ready"}, 32'(ready2), 32'd1);
                check({tag, "/done_we_n"}, 32'(we_n2), 32'd1);
                check({tag, "/done_oe_n"}, 32'(oe_n2), 32'd1);
                check({tag, "/done_dq"}, 32'(dq2), 32'd0);
                if (!wr && known) check({tag, "/rdata"}, rdata2, exp_rd);
                if (wr) check({tag, "/rdata_hold"}, rdata2, last_rd);
            end
            @(posedge clk); #1;
        end
        if (wr) ref_mem[idx] = data;
        else if (known) last_rd = exp_rd;
    endtask

    task automatic idle_cycles(input int n);
        wr_en = 1'b0; rd_en = 1'b0; probe_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle/ready", 32'(ready2), 32'd1);
            check("idle/we_oe", {30'd0, we_n2, oe_n2}, 32'd3);
            check("idle/dq", 32'(dq2), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Same request to all three instances; record first ready cycle of each
    task automatic lat_run(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int l1, l2, l4;
        logic [31:0] r1, r2, r4;
        l1 = -1; l2 = -1; l4 = -1;
        r1 = 32'd0; r2 = 32'd0; r4 = 32'd0;
        probe_en = 1'b0;
        wr_en = wr; rd_en = !wr; address = addr; write_data = data;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (l1 < 0 && c > 0 && ready1) begin l1 = c; r1 = rdata1; end
            if (l2 < 0 && c > 0 && ready2) begin l2 = c; r2 = rdata2; end
            if (l4 < 0 && c > 0 && ready4) begin l4 = c; r4 = rdata4; end
            @(posedge clk); #1;
            if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("lat/ac1", 32'(l1), 32'd3);
        check("lat/ac2", 32'(l2), 32'd5);
        check("lat/ac4", 32'(l4), 32'd9);
        if (!wr) begin
            check("lat/rdata_ac1", r1, data);
            check("lat/rdata_ac2", r2, data);
            check("lat/rdata_ac4", r4, data);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q_addr [$];
        logic [31:0] a, d, rst_addr;
        int unsigned ridx;

        // Reset state
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        probe_en = 1'b1; last_rd = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/ready", 32'(ready2), 32'd1);
        check("rst/we_oe", {30'd0, we_n2, oe_n2}, 32'd3);
        check("rst/addr", 32'(addr2), 32'd0);
        check("rst/rdata", rdata2, 32'd0);
        check("rst/dq", 32'(dq2), 32'd0);
        check("rst/ties", {23'd0, ce_n2, ub_n2, lb_n2, ce_n1, ub_n1, lb_n1, ce_n4, ub_n4, lb_n4}, 32'd0);
        rd_en = 1'b1; #1;
        check("rst/ready_req", 32'(ready2), 32'd0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // No request: idle indefinitely
        idle_cycles(4);

        // Write then read back at word 0
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr1024");
        idle_cycles(2);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, "rd1024");
        idle_cycles(1);

        // Address mapping: idx 3, read via unaligned byte address
        d = $urandom;
        do_access(1'b1, 1'b0, 32'd1036, d, "wr1036");
        idle_cycles(1);
        do_access(1'b0, 1'b1, 32'd1039, 32'h0, "rd1039");

        // Back-to-back with no idle gap
        do_access(1'b1, 1'b0, 32'd1028, 32'h11112222, "b2b_wr");
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, "b2b_rd");
        idle_cycles(1);

        // Both requests high: write wins
        d = $urandom;
        do_access(1'b1, 1'b1, 32'd1040, d, "conflict");
        do_access(1'b0, 1'b1, 32'd1040, 32'h0, "conflict_rd");

        // Address below base wraps to the top of the SRAM
        d = $urandom;
        do_access(1'b1, 1'b0, 32'd1020, d, "wrap_wr");
        do_access(1'b0, 1'b1, 32'd1020, 32'h0, "wrap_rd");
        idle_cycles(1);

        // Randomized writes, then aliased / unaligned reads back
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'd4 * 32'($urandom_range(4, 40)) + 32'($urandom_range(0, 3));
            q_addr.push_back(a);
            do_access(1'b1, 1'b0, a, $urandom, "rnd_wr");
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end
        while (q_addr.size() > 0) begin
            a = q_addr.pop_back();
            a = a ^ (32'($urandom_range(0, 1)) << 19) ^ 32'($urandom_range(0, 3));
            do_access(1'b0, 1'b1, a, 32'h0, "rnd_rd");
        end
        idle_cycles(1);

        // Reset during the HIGH phase of a write
        rst_addr = 32'd1100;
        ridx = model_idx(rst_addr);
        probe_en = 1'b0;
        wr_en = 1'b1; address = rst_addr; write_data = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstmid/high_addr", 32'(addr2), 32'(ridx * 2 + 1));
        check("rstmid/high_we_n", 32'(we_n2), 32'd0);
        #1 rst = 1'b1; wr_en = 1'b0;
        #1 probe_en = 1'b1;
        #1;
        check("rstmid/ready", 32'(ready2), 32'd1);
        check("rstmid/we_oe", {30'd0, we_n2, oe_n2}, 32'd3);
        check("rstmid/addr", 32'(addr2), 32'd0);
        check("rstmid/rdata", rdata2, 32'd0);
        check("rstmid/dq", 32'(dq2), 32'd0);
        ref_mem.delete(ridx);
        last_rd = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(1);
        do_access(1'b0, 1'b1, 32'd1036, 32'h0, "post_rst_rd");

        // Latency across ACCESS_CYCLES = 1, 2, 4
        idle_cycles(12);
        d = $urandom;
        lat_run(1'b1, 32'd1824, d);
        lat_run(1'b0, 32'd1824, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
